hdmi_tmds_encoder_3ch: RTL and testbench

Three-channel TMDS (DVI 1.0 8b/10b) encoder for the HDMI output path. Consumes the cropped 1920x1080 hs/vs/de timing, plus pixel-aligned 24-bit RGB, and produces three 10-bit TMDS symbols per pixel clock for the downstream 10:1 serializers. The encoder is a two-stage pipeline with per-channel running-disparity tracking.

---
 rtl/hdmi_tmds_encoder_3ch.sv | 143 ++++++++++++++
 tb/tb_hdmi_tmds_encoder_3ch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_tmds_encoder_3ch.sv
// Three-channel DVI/HDMI TMDS 8b/10b encoder: stage 1 minimises transitions, stage 2 balances DC
// with an independent running disparity per channel. Channel 0 = blue, 1 = green, 2 = red.
module hdmi_tmds_encoder_3ch #(
    parameter logic HS_INV = 1'b0,
    parameter logic VS_INV = 1'b0
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic       i_hs,
    input  logic       i_vs,
    input  logic       i_de,
    input  logic [7:0] i_r,
    input  logic [7:0] i_g,
    input  logic [7:0] i_b,
    output logic [9:0] o_tmds_ch0,
    output logic [9:0] o_tmds_ch1,
    output logic [9:0] o_tmds_ch2
);

    localparam logic [9:0] CtrlSym00 = 10'h354;
    localparam logic [9:0] CtrlSym01 = 10'h0AB;
    localparam logic [9:0] CtrlSym10 = 10'h154;
    localparam logic [9:0] CtrlSym11 = 10'h2AB;

    function automatic logic [3:0] count_ones(input logic [7:0] d);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, d[i]};
        end
        return n;
    endfunction

    // Bit 8 of the result flags XOR (1) versus XNOR (0) chaining.
    function automatic logic [8:0] minimise_transitions(input logic [7:0] d);
        logic [3:0] n;
        logic       use_xnor;
        logic [8:0] q;
        n        = count_ones(d);
        use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] control_symbol(input logic [1:0] c);
        logic [9:0] s;
        unique case (c)
            2'b00:   s = CtrlSym00;
            2'b01:   s = CtrlSym01;
            2'b10:   s = CtrlSym10;
            default: s = CtrlSym11;
        endcase
        return s;
    endfunction

    // ---------------------------------------------------------------- stage 1
    logic [2:0][7:0] pix_data;
    logic [2:0][8:0] qm_s1_d;
    logic [2:0][8:0] qm_s1_q;
    logic            de_s1_q;
    logic [1:0]      ctrl_s1_q;

    assign pix_data = {i_r, i_g, i_b};

    always_comb begin
        qm_s1_d = '0;
        for (int ch = 0; ch < 3; ch++) begin
            qm_s1_d[ch] = minimise_transitions(pix_data[ch]);
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            de_s1_q   <= 1'b0;
            ctrl_s1_q <= 2'b00;
            qm_s1_q   <= '0;
        end else begin
            de_s1_q   <= i_de;
            ctrl_s1_q <= {i_vs ^ VS_INV, i_hs ^ HS_INV};
            qm_s1_q   <= qm_s1_d;
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic [2:0][9:0] sym_d;
    logic [2:0][9:0] sym_q;
    logic [2:0][4:0] cnt_d;
    logic [2:0][4:0] cnt_q;

    // Sums are formed at 6 bits so intermediate terms never wrap; the result fits in 5.
    always_comb begin
        sym_d = '0;
        cnt_d = '0;
        for (int ch = 0; ch < 3; ch++) begin
            logic [8:0]        qm;
            logic [3:0]        ones;
            logic signed [5:0] diff;
            logic signed [5:0] cnt_cur;
            logic signed [5:0] cnt_nxt;

            qm      = qm_s1_q[ch];
            ones    = count_ones(qm[7:0]);
            diff    = $signed({1'b0, ones, 1'b0}) - 6'sd8;
            cnt_cur = $signed({cnt_q[ch][4], cnt_q[ch]});
            cnt_nxt = 6'sd0;

            if (!de_s1_q) begin
                sym_d[ch] = control_symbol((ch == 0) ? ctrl_s1_q : 2'b00);
                cnt_nxt   = 6'sd0;
            end else if ((cnt_cur == 6'sd0) || (diff == 6'sd0)) begin
                sym_d[ch] = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                cnt_nxt   = qm[8] ? (cnt_cur + diff) : (cnt_cur - diff);
            end else if (((cnt_cur > 6'sd0) && (diff > 6'sd0)) ||
                         ((cnt_cur < 6'sd0) && (diff < 6'sd0))) begin
                sym_d[ch] = {1'b1, qm[8], ~qm[7:0]};
                cnt_nxt   = cnt_cur - diff + (qm[8] ? 6'sd2 : 6'sd0);
            end else begin
                sym_d[ch] = {1'b0, qm[8], qm[7:0]};
                cnt_nxt   = cnt_cur + diff - (qm[8] ? 6'sd0 : 6'sd2);
            end
            cnt_d[ch] = cnt_nxt[4:0];
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            sym_q <= {3{CtrlSym00}};
            cnt_q <= '0;
        end else begin
            sym_q <= sym_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_tmds_ch0 = sym_q[0];
    assign o_tmds_ch1 = sym_q[1];
    assign o_tmds_ch2 = sym_q[2];

endmodule

// File: tb/tb_hdmi_tmds_encoder_3ch.sv
// Self-checking bench for hdmi_tmds_encoder_3ch: constant vector table, hand sequences and a
// behavioural-model scoreboard; a second instance runs with HS_INV=1.
module tb_hdmi_tmds_encoder_3ch;

    logic       pixel_clk = 1'b0;
    logic       rst = 1'b1;
    logic       hs = 1'b0, vs = 1'b0, de = 1'b0;
    logic [7:0] r = '0, g = '0, b = '0;
    logic [9:0] ch0, ch1, ch2, inv_ch0, inv_ch1, inv_ch2;

    always #5 pixel_clk = ~pixel_clk;

    hdmi_tmds_encoder_3ch #(.HS_INV(1'b0), .VS_INV(1'b0)) dut (
        .pixel_clk(pixel_clk), .rst(rst), .i_hs(hs), .i_vs(vs), .i_de(de),
        .i_r(r), .i_g(g), .i_b(b),
        .o_tmds_ch0(ch0), .o_tmds_ch1(ch1), .o_tmds_ch2(ch2)
    );

    hdmi_tmds_encoder_3ch #(.HS_INV(1'b1), .VS_INV(1'b0)) dut_inv (
        .pixel_clk(pixel_clk), .rst(rst), .i_hs(hs), .i_vs(vs), .i_de(de),
        .i_r(r), .i_g(g), .i_b(b),
        .o_tmds_ch0(inv_ch0), .o_tmds_ch1(inv_ch1), .o_tmds_ch2(inv_ch2)
    );

    typedef struct packed {
        logic        rst, hs, vs, de;
        logic [7:0]  r, g, b;
        logic        use_exp;
        logic [9:0]  e0, e1, e2, ei;
        logic [63:0] tag;
    } vec_t;

    typedef struct packed {
        logic        act;
        logic [9:0]  e0, e1, e2, ei;
        logic [63:0] tag;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cnt_m[3];
    int   acc[3];

    function automatic int ones10(input logic [9:0] s);
        int n = 0;
        for (int i = 0; i < 10; i++) n += int'(s[i]);
        return n;
    endfunction

    function automatic logic [9:0] ctrl_sym(input logic c1, input logic c0);
        case ({c1, c0})
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    function automatic logic [9:0] model_sym(input logic [7:0] d, input int cnt_in);
        int         n1d, n1, n0;
        logic       xn;
        logic [8:0] qm;
        n1d = 0;
        for (int i = 0; i < 8; i++) n1d += int'(d[i]);
        xn = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~xn;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
        n0 = 8 - n1;
        if (cnt_in == 0 || n1 == n0)
            return qm[8] ? {2'b01, qm[7:0]} : {2'b10, ~qm[7:0]};
        else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1))
            return {1'b1, qm[8], ~qm[7:0]};
        else
            return {1'b0, qm[8], qm[7:0]};
    endfunction

    function automatic vec_t px(input logic rs, input logic h, input logic v, input logic e,
                                input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                                input logic [63:0] tag);
        vec_t x;
        x = '{rst: rs, hs: h, vs: v, de: e, r: rr, g: gg, b: bb, use_exp: 1'b0,
              e0: '0, e1: '0, e2: '0, ei: '0, tag: tag};
        return x;
    endfunction

    function automatic vec_t ex(input logic h, input logic v, input logic e, input logic [7:0] d,
                                input logic [9:0] e0, input logic [9:0] e12,
                                input logic [9:0] ei, input logic [63:0] tag);
        vec_t x;
        x = px(1'b0, h, v, e, d, d, d, tag);
        x.use_exp = 1'b1;
        x.e0 = e0; x.e1 = e12; x.e2 = e12; x.ei = ei;
        return x;
    endfunction

    task automatic cmp(input logic [63:0] tag, input string ch, input logic [9:0] got,
                       input logic [9:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %0s.%0s got %h want %h", tag, ch, got, want);
        end
    endtask

    task automatic step(input vec_t v);
        exp_t        e, last;
        logic [7:0]  d[3];
        logic [9:0]  outs[3];
        @(negedge pixel_clk);
        rst = v.rst; hs = v.hs; vs = v.vs; de = v.de; r = v.r; g = v.g; b = v.b;
        d[0] = v.b; d[1] = v.g; d[2] = v.r;
        e.tag = v.tag;
        e.act = v.de && !v.rst;
        if (v.rst) begin
            // The pixel already in stage 1 is discarded: its slot shows the reset symbol too.
            if (exp_q.size() == 0) begin
                exp_q.push_back('{act: 1'b0, e0: 10'h354, e1: 10'h354, e2: 10'h354,
                                  ei: 10'h354, tag: v.tag});
            end else begin
                last = exp_q[exp_q.size()-1];
                last.act = 1'b0;
                last.e0 = 10'h354; last.e1 = 10'h354; last.e2 = 10'h354; last.ei = 10'h354;
                exp_q[exp_q.size()-1] = last;
            end
            e.e0 = 10'h354; e.e1 = 10'h354; e.e2 = 10'h354; e.ei = 10'h354;
            for (int c = 0; c < 3; c++) cnt_m[c] = 0;
        end else if (!v.de) begin
            e.e0 = ctrl_sym(v.vs, v.hs);
            e.e1 = 10'h354;
            e.e2 = 10'h354;
            e.ei = ctrl_sym(v.vs, ~v.hs);
            for (int c = 0; c < 3; c++) cnt_m[c] = 0;
        end else begin
            e.e0 = model_sym(d[0], cnt_m[0]);
            e.e1 = model_sym(d[1], cnt_m[1]);
            e.e2 = model_sym(d[2], cnt_m[2]);
            e.ei = e.e0;
            cnt_m[0] += 2 * ones10(e.e0) - 10;
            cnt_m[1] += 2 * ones10(e.e1) - 10;
            cnt_m[2] += 2 * ones10(e.e2) - 10;
        end
        if (v.use_exp) begin
            e.e0 = v.e0; e.e1 = v.e1; e.e2 = v.e2; e.ei = v.ei;
        end
        exp_q.push_back(e);
        @(posedge pixel_clk);
        #1;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            cmp(e.tag, "ch0", ch0, e.e0);
            cmp(e.tag, "ch1", ch1, e.e1);
            cmp(e.tag, "ch2", ch2, e.e2);
            cmp(e.tag, "inv0", inv_ch0, e.ei);
            outs[0] = ch0; outs[1] = ch1; outs[2] = ch2;
            for (int c = 0; c < 3; c++) begin
                if (e.act) begin
                    acc[c] += 2 * ones10(outs[c]) - 10;
                    n_cmp++;
                    if (acc[c] > 10 || acc[c] < -10) begin
                        n_err++;
                        $display("FAIL %0s.disp%0d got %0d want within +/-10", e.tag, c, acc[c]);
                    end
                end else begin
                    acc[c] = 0;
                end
            end
        end
    endtask

    logic [7:0] special[8];

    initial begin
        for (int c = 0; c < 3; c++) begin
            cnt_m[c] = 0;
            acc[c] = 0;
        end

        // Constant vectors: control codes, zero-data and all-ones disparity walks.
        tbl.push_back(ex(0, 0, 0, 8'h00, 10'h354, 10'h354, 10'h0AB, "ctl00"));
        tbl.push_back(ex(1, 0, 0, 8'h00, 10'h0AB, 10'h354, 10'h354, "ctl01"));
        tbl.push_back(ex(0, 1, 0, 8'h00, 10'h154, 10'h354, 10'h2AB, "ctl10"));
        tbl.push_back(ex(1, 1, 0, 8'h00, 10'h2AB, 10'h354, 10'h154, "ctl11"));
        tbl.push_back(ex(0, 0, 0, 8'h00, 10'h354, 10'h354, 10'h0AB, "blank"));
        for (int i = 0; i < 6; i++) begin
            tbl.push_back(ex(0, 0, 1, 8'h00, (i % 2 == 0) ? 10'h100 : 10'h3FF,
                             (i % 2 == 0) ? 10'h100 : 10'h3FF,
                             (i % 2 == 0) ? 10'h100 : 10'h3FF, "zero"));
        end
        tbl.push_back(ex(0, 0, 0, 8'h00, 10'h354, 10'h354, 10'h0AB, "blank"));
        tbl.push_back(ex(0, 0, 1, 8'hFF, 10'h200, 10'h200, 10'h200, "ones0"));
        tbl.push_back(ex(0, 0, 1, 8'hFF, 10'h0FF, 10'h0FF, 10'h0FF, "ones1"));
        tbl.push_back(ex(0, 0, 1, 8'hFF, 10'h0FF, 10'h0FF, 10'h0FF, "ones2"));
        tbl.push_back(ex(0, 0, 1, 8'hFF, 10'h200, 10'h200, 10'h200, "ones3"));
        tbl.push_back(ex(0, 0, 0, 8'h00, 10'h354, 10'h354, 10'h0AB, "deflow"));
        tbl.push_back(ex(0, 0, 1, 8'hFF, 10'h200, 10'h200, 10'h200, "onesrst"));
        tbl.push_back(ex(0, 0, 0, 8'h00, 10'h354, 10'h354, 10'h0AB, "blank"));

        // Reset held 3 cycles with random inputs, then release.
        for (int i = 0; i < 3; i++) begin
            step(px(1, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), "rst"));
        end
        step(px(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, "rstrel"));

        foreach (tbl[i]) step(tbl[i]);

        // Reset mid-line with ch0 disparity non-zero, then a zero pixel from cnt=0.
        step(px(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, "mlblank"));
        for (int i = 0; i < 3; i++) step(px(0, 0, 0, 1, 8'h00, 8'h00, 8'h00, "mlpix"));
        step(px(1, 0, 0, 1, 8'h00, 8'h00, 8'h00, "mlrst"));
        step(ex(0, 0, 1, 8'h00, 10'h100, 10'h100, 10'h100, "mlfirst"));
        step(ex(0, 0, 1, 8'h00, 10'h3FF, 10'h3FF, 10'h3FF, "mlsecond"));
        step(px(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, "mlend"));

        // Threshold data words around N1==4 and alternating patterns.
        special = '{8'h0F, 8'h1E, 8'hF0, 8'h10, 8'hEF, 8'h55, 8'hAA, 8'h3C};
        for (int i = 0; i < 24; i++) begin
            step(px(0, 0, 0, 1, special[i % 8], special[(i + 3) % 8], special[(i + 5) % 8],
                    "thresh"));
        end
        step(px(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, "thend"));

        // Scaled-down frame: hs pulse in blanking, vs on first line, hs/vs noise while active.
        for (int ln = 0; ln < 4; ln++) begin
            for (int k = 0; k < 12; k++) begin
                step(px(0, (k >= 2 && k < 6), (ln == 0), 0, 8'($urandom), 8'($urandom),
                        8'($urandom), "frmblk"));
            end
            for (int k = 0; k < 40; k++) begin
                step(px(0, 1'($urandom), 1'($urandom), 1, 8'($urandom), 8'($urandom),
                        8'($urandom), "frmpix"));
            end
        end

        // Irregular de bursts.
        for (int k = 0; k < 80; k++) begin
            step(px(0, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 8'($urandom),
                    8'($urandom), 8'($urandom), "burst"));
        end
        for (int k = 0; k < 3; k++) step(px(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, "flush"));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
